// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//
// Fetch-side program counter owner. Advances the PC sequentially, holds it
// on a decode hazard stall, and loads a redirect target reported by the
// writeback stage (jump-via-memory has priority over register jump / taken
// branch). Each accepted redirect raises flush for FLUSH_CYCLES cycles so the
// wrong-path instructions already in IF/ID, ID/EX and EX/MEM are squashed.
// While flushing, the PC holds the target and further redirect indications
// are ignored, since they can only come from squashed or bubble slots.
//
// Ports:
//   clk           system clock, rising-edge
//   rst_n         synchronous active-low reset
//   stall         hazard stall from decode (hold PC in RUN)
//   jump_mem      WB jump-via-memory valid, target on data_wb
//   branch_taken  WB register jump / taken branch valid, target on rs_wb
//   data_wb       memory-data jump target
//   rs_wb         register jump / branch target
//   pc            current fetch address (registered)
//   pc_plus1      pc + 1, combinational, wraps modulo 2^ADDR_W
//   flush         squash strobe for IF/ID, ID/EX, EX/MEM (registered)
//   redirect_sel  last redirect source: 0 sequential, 1 rs_wb, 2 data_wb
//   redirect_cnt  count of accepted redirects, wraps at 16 bits

module pc_fetch_ctrl #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                FLUSH_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              jump_mem,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] data_wb,
    input  logic [ADDR_W-1:0] rs_wb,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              flush,
    output logic [1:0]        redirect_sel,
    output logic [15:0]       redirect_cnt
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
        $error("pc_fetch_ctrl: FLUSH_CYCLES must be in 1..15");
    end

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [1:0]        SEL_SEQ  = 2'd0;
    localparam logic [1:0]        SEL_RS   = 2'd1;
    localparam logic [1:0]        SEL_DATA = 2'd2;
    localparam logic [3:0]        CNT_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              flush_q, flush_d;
    logic [1:0]        sel_q, sel_d;
    logic [15:0]       rcnt_q, rcnt_d;

    // Sequential address is also exported for the adder path.
    assign pc_plus1 = pc_q + PC_ONE;

    // ---- State register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            sel_q   <= SEL_SEQ;
            rcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            sel_q   <= sel_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // ---- Next-state / next-PC logic ----
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        flush_d = flush_q;
        sel_d   = sel_q;
        rcnt_d  = rcnt_q;

        case (state_q)
            RUN: begin
                // A redirect wins over a stall: the stalled instruction is
                // on the wrong path anyway and is about to be squashed.
                if (jump_mem || branch_taken) begin
                    pc_d    = jump_mem ? data_wb : rs_wb;
                    sel_d   = jump_mem ? SEL_DATA : SEL_RS;
                    rcnt_d  = rcnt_q + 16'd1;
                    flush_d = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = FLUSH;
                end else if (stall) begin
                    sel_d = SEL_SEQ;
                end else begin
                    pc_d  = pc_plus1;
                    sel_d = SEL_SEQ;
                end
            end

            FLUSH: begin
                // PC parks on the target; stall and redirect inputs are
                // don't-cares until the countdown expires.
                if (cnt_q == 4'd0) begin
                    flush_d = 1'b0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = RUN;
                flush_d = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign pc           = pc_q;
    assign flush        = flush_q;
    assign redirect_sel = sel_q;
    assign redirect_cnt = rcnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    localparam int FC = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: 32-bit, RESET_PC 0, three flush cycles
    logic        rst_n, stall, jump_mem, branch_taken;
    logic [31:0] data_wb, rs_wb, pc, pc_plus1;
    logic        flush;
    logic [1:0]  redirect_sel;
    logic [15:0] redirect_cnt;

    pc_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .jump_mem(jump_mem),
        .branch_taken(branch_taken), .data_wb(data_wb), .rs_wb(rs_wb),
        .pc(pc), .pc_plus1(pc_plus1), .flush(flush),
        .redirect_sel(redirect_sel), .redirect_cnt(redirect_cnt)
    );

    // Narrow instance: 8-bit wrap, nonzero reset PC, single flush cycle
    logic        rst8_n, stall8, jm8, bt8;
    logic [7:0]  d8, rs8, pc8, pcp8;
    logic        flush8;
    logic [1:0]  sel8;
    logic [15:0] cnt8;

    pc_fetch_ctrl #(.ADDR_W(8), .RESET_PC(8'hF0), .FLUSH_CYCLES(1)) dut8 (
        .clk(clk), .rst_n(rst8_n), .stall(stall8), .jump_mem(jm8),
        .branch_taken(bt8), .data_wb(d8), .rs_wb(rs8),
        .pc(pc8), .pc_plus1(pcp8), .flush(flush8),
        .redirect_sel(sel8), .redirect_cnt(cnt8)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rst_n, stall, jm, bt;
        logic [31:0] data, rs;
        logic [31:0] e_pc;
        logic        e_flush;
        logic [1:0]  e_sel;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic j, input logic b,
                         input logic [31:0] d, input logic [31:0] t);
        rst_n = r; stall = s; jump_mem = j; branch_taken = b; data_wb = d; rs_wb = t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_main(input string nm, input logic [31:0] e_pc, input logic e_f,
                               input logic [1:0] e_s, input logic [15:0] e_c);
        chk({nm, ".pc"}, pc, e_pc);
        chk({nm, ".pc_plus1"}, pc_plus1, e_pc + 32'd1);
        chk({nm, ".flush"}, {31'd0, flush}, {31'd0, e_f});
        chk({nm, ".sel"}, {30'd0, redirect_sel}, {30'd0, e_s});
        chk({nm, ".cnt"}, {16'd0, redirect_cnt}, {16'd0, e_c});
    endtask

    task automatic add(input logic r, input logic s, input logic j, input logic b,
                       input logic [31:0] d, input logic [31:0] t, input logic [31:0] p,
                       input logic f, input logic [1:0] sl, input logic [15:0] c);
        vec_t v;
        v.rst_n = r; v.stall = s; v.jm = j; v.bt = b; v.data = d; v.rs = t;
        v.e_pc = p; v.e_flush = f; v.e_sel = sl; v.e_cnt = c;
        vecs.push_back(v);
    endtask

    // Reference model: a flush is a number of remaining squash cycles, not a state.
    logic [31:0] m_pc;
    int          m_rem;
    logic [1:0]  m_sel;
    logic [15:0] m_cnt;

    task automatic model_edge(input logic r, input logic s, input logic j, input logic b,
                              input logic [31:0] d, input logic [31:0] t);
        if (!r) begin
            m_pc = 0; m_rem = 0; m_sel = 0; m_cnt = 0;
        end else if (m_rem > 0) begin
            m_rem--;
        end else if (j || b) begin
            m_pc  = j ? d : t;
            m_sel = j ? 2'd2 : 2'd1;
            m_cnt = m_cnt + 1;
            m_rem = FC;
        end else if (s) begin
            m_sel = 0;
        end else begin
            m_pc  = m_pc + 1;
            m_sel = 0;
        end
    endtask

    initial begin
        rst8_n = 1'b0; stall8 = 0; jm8 = 0; bt8 = 0; d8 = 0; rs8 = 0;
        drive(0, 0, 0, 0, 0, 0);

        // Reset, sequential run, register branch, simultaneous redirect+stall
        add(0,0,0,0, 0,0,          32'h0,   0, 0, 0);
        add(0,0,0,0, 0,0,          32'h0,   0, 0, 0);
        add(1,0,0,0, 0,0,          32'h1,   0, 0, 0);
        add(1,0,0,0, 0,0,          32'h2,   0, 0, 0);
        add(1,0,0,0, 0,0,          32'h3,   0, 0, 0);
        add(1,0,0,0, 0,0,          32'h4,   0, 0, 0);
        add(1,0,0,1, 0,32'h40,     32'h40,  1, 1, 1);
        add(1,0,0,0, 0,0,          32'h40,  1, 1, 1);
        add(1,0,0,0, 0,0,          32'h40,  1, 1, 1);
        add(1,0,0,0, 0,0,          32'h40,  0, 1, 1);
        add(1,0,0,0, 0,0,          32'h41,  0, 0, 1);
        add(1,0,0,0, 0,0,          32'h42,  0, 0, 1);
        add(1,1,1,1, 32'h100,32'h200, 32'h100, 1, 2, 2);
        add(1,1,0,0, 0,0,          32'h100, 1, 2, 2);
        add(1,1,0,0, 0,0,          32'h100, 1, 2, 2);
        add(1,1,0,0, 0,0,          32'h100, 0, 2, 2);
        add(1,1,0,0, 0,0,          32'h100, 0, 0, 2);
        add(1,0,0,0, 0,0,          32'h101, 0, 0, 2);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].stall, vecs[i].jm, vecs[i].bt, vecs[i].data, vecs[i].rs);
            step();
            expect_main($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_flush,
                        vecs[i].e_sel, vecs[i].e_cnt);
        end

        // Redirect during FLUSH is ignored; the first RUN edge may redirect again
        drive(1,0,0,1, 0,32'h40);      step(); expect_main("fl_redir", 32'h40, 1, 1, 3);
        drive(1,0,1,1, 32'h90,32'h80); step(); expect_main("fl_ign1", 32'h40, 1, 1, 3);
        drive(1,1,0,1, 0,32'h80);      step(); expect_main("fl_ign2", 32'h40, 1, 1, 3);
        drive(1,0,0,0, 0,0);           step(); expect_main("fl_exit", 32'h40, 0, 1, 3);
        drive(1,0,1,0, 32'h55,0);      step(); expect_main("fl_rerun", 32'h55, 1, 2, 4);

        // Reset in the second flush cycle, together with a redirect request
        drive(1,0,0,0, 0,0); step(); expect_main("rs_f2", 32'h55, 1, 2, 4);
        drive(0,0,0,1, 0,32'h77); step(); expect_main("rs_mid", 32'h0, 0, 0, 0);
        drive(1,0,0,0, 0,0); step(); expect_main("rs_seq1", 32'h1, 0, 0, 0);
        step(); expect_main("rs_seq2", 32'h2, 0, 0, 0);

        // Narrow instance: reset value, 1-cycle flush, stall hold, wrap
        step();
        chk("w8.reset_pc", {24'd0, pc8}, 32'hF0);
        rst8_n = 1; bt8 = 1; rs8 = 8'hFE; step(); bt8 = 0;
        chk("w8.redir_pc", {24'd0, pc8}, 32'hFE);
        chk("w8.redir_flush", {31'd0, flush8}, 32'd1);
        stall8 = 1; step();
        chk("w8.flush1_done", {31'd0, flush8}, 32'd0);
        chk("w8.flush1_pc", {24'd0, pc8}, 32'hFE);
        step(); chk("w8.stall_a", {24'd0, pc8}, 32'hFE);
        step(); chk("w8.stall_b", {24'd0, pc8}, 32'hFE);
        chk("w8.stall_sel", {30'd0, sel8}, 32'd0);
        stall8 = 0; step();
        chk("w8.pc_ff", {24'd0, pc8}, 32'hFF);
        chk("w8.plus1_wrap", {24'd0, pcp8}, 32'h00);
        step();
        chk("w8.pc_wrap", {24'd0, pc8}, 32'h00);
        chk("w8.cnt", {16'd0, cnt8}, 32'd1);

        // Randomized run against the reference model
        drive(0,0,0,0, 0,0); step();
        model_edge(0,0,0,0, 0,0);
        expect_main("rnd_rst", m_pc, m_rem > 0, m_sel, m_cnt);
        for (int k = 0; k < 600; k++) begin
            logic r, s, j, b;
            logic [31:0] d, t;
            r = ($urandom_range(0, 59) != 0);
            s = ($urandom_range(0, 3) == 0);
            j = ($urandom_range(0, 7) == 0);
            b = ($urandom_range(0, 5) == 0);
            d = $urandom;
            t = $urandom;
            if (k % 97 == 5) d = 32'hFFFF_FFFF;
            drive(r, s, j, b, d, t);
            step();
            model_edge(r, s, j, b, d, t);
            expect_main($sformatf("rnd%0d", k), m_pc, m_rem > 0, m_sel, m_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch-side partner of the writeback-stage next-PC select path: owns the program counter register and consumes the WB-stage redirect indications (jump-via-memory, register jump/taken branch).
- Also generates the pipeline flush that squashes wrong-path instructions after a redirect.
- Sits at the front of the pipeline, drives the instruction-memory address, and feeds pc_plus1 to the adder path.

Parameters:
- ADDR_W, 32, width of PC and target buses.
- RESET_PC, 0, PC value loaded on reset.
- FLUSH_CYCLES, 3, cycles flush stays asserted after a redirect (1..15).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  hazard stall from decode; hold PC when high in RUN.
- jump_mem  in  1  WB-stage jump-via-memory valid; target on data_wb.
- branch_taken  in  1  WB-stage register jump or taken branch valid; target on rs_wb.
- data_wb  in  ADDR_W  memory-data jump target.
- rs_wb  in  ADDR_W  register jump/branch target.
- pc  out  ADDR_W  current fetch address.
- pc_plus1  out  ADDR_W  pc + 1, combinational, modulo 2^ADDR_W.
- flush  out  1  squash IF/ID, ID/EX, EX/MEM registers.
- redirect_sel  out  2  last redirect source: 0 sequential, 1 rs_wb, 2 data_wb.
- redirect_cnt  out  16  count of accepted redirects.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low on rst_n. All registers update only on the rising edge of clk.
- Reset values, with rst_n low at an edge:
  - pc = RESET_PC, flush = 0, redirect_sel = 0, redirect_cnt = 0.
  - State = RUN, flush counter = 0.
  - Reset overrides everything, including mid-FLUSH and a simultaneous redirect.
- FSM states: RUN, FLUSH.
- RUN, evaluated at each edge in this priority order:
  1. jump_mem = 1: pc <= data_wb; redirect_sel <= 2; redirect_cnt += 1; flush <= 1; cnt <= FLUSH_CYCLES-1; go to FLUSH.
  2. else branch_taken = 1: pc <= rs_wb; redirect_sel <= 1; redirect_cnt += 1; flush <= 1; cnt <= FLUSH_CYCLES-1; go to FLUSH.
  3. else stall = 1: pc holds; redirect_sel <= 0.
  4. else pc <= pc + 1 (wraps from all-ones to 0); redirect_sel <= 0.
- Priority and stall interaction:
  - jump_mem and branch_taken both high: jump_mem wins; only one redirect is counted.
  - Redirect beats stall: PC loads the target even when stall = 1.
- FLUSH, at each edge:
  - pc holds the target.
  - If cnt = 0: flush <= 0, go to RUN. Else cnt -= 1.
  - flush is therefore high for exactly FLUSH_CYCLES consecutive cycles, starting the cycle after the redirect edge.
  - jump_mem and branch_taken are ignored (they come from squashed or bubble slots); redirect_cnt does not change.
  - stall has no effect; the countdown continues.
- Exit from FLUSH: on the first RUN edge, the normal RUN rules apply. That edge can itself take a new redirect.
- Timing: pc, flush, redirect_sel and redirect_cnt are registered. pc_plus1 is purely combinational from pc.
- Widths: targets are used as given, with no alignment or truncation. redirect_cnt wraps 0xFFFF -> 0.
- FLUSH_CYCLES = 1 gives one flush cycle and returns to RUN on the next edge.

Test Plan:
- Reset then sequential run: rst_n=0 for 2 cycles, then 1, all controls 0, 5 cycles -> pc = 0,1,2,3,4; flush = 0; redirect_sel = 0.
- Register branch: at pc=4, branch_taken=1 for 1 cycle with rs_wb=0x40 -> next pc = 0x40, redirect_sel = 1, flush = 1 for 3 cycles with pc held at 0x40, then pc = 0x41, 0x42; redirect_cnt = 1.
- Simultaneous redirect and stall: stall=1, jump_mem=1, branch_taken=1, data_wb=0x100, rs_wb=0x200 -> pc = 0x100, redirect_sel = 2, redirect_cnt increments by exactly 1.
- Redirect during FLUSH: 1 cycle after a redirect to 0x40, pulse branch_taken with rs_wb=0x80 -> ignored; pc stays 0x40; redirect_cnt unchanged; flush drops after 3 cycles total.
- Stall and wrap: ADDR_W=8 with pc=0xFE:
  - stall=1 for 2 cycles -> pc holds 0xFE.
  - Release -> pc = 0xFF, then 0x00; pc_plus1 reads 0x00 while pc = 0xFF.
- Reset mid-flush: assert rst_n=0 in the 2nd flush cycle -> next edge pc = RESET_PC, flush = 0, redirect_cnt = 0; after release, sequential fetch resumes from RESET_PC.
